// File: rtl/lrc_pkg.sv
// lrc_pkg: shared definitions for the LRC stream engine.
//   - LRC_XOR / LRC_ADD : mode encodings carried on cfg_mode.
//   - lane_state_t      : per-channel frame state (IDLE / ACTIVE).
//   - lrc_fold          : folds one beat into an accumulator.
//   - lrc_final         : turns an accumulator into the transmitted LRC.
// The functions work on a fixed LRC_MAX_W-bit width so that any DATA_W up to
// that width can share them. Callers zero-extend their operands and truncate
// the result back to DATA_W. XOR, addition and two's-complement negation are
// all correct modulo 2**DATA_W after that truncation.
package lrc_pkg;

  localparam logic LRC_XOR = 1'b0;
  localparam logic LRC_ADD = 1'b1;

  localparam int LRC_MAX_W = 64;

  typedef enum logic {
    LANE_IDLE   = 1'b0,
    LANE_ACTIVE = 1'b1
  } lane_state_t;

  function automatic logic [LRC_MAX_W-1:0] lrc_fold(
    input logic                 mode,
    input logic [LRC_MAX_W-1:0] acc,
    input logic [LRC_MAX_W-1:0] data
  );
    logic [LRC_MAX_W-1:0] r;
    case (mode)
      LRC_XOR: r = acc ^ data;
      LRC_ADD: r = acc + data;
      default: r = acc ^ data;
    endcase
    return r;
  endfunction

  function automatic logic [LRC_MAX_W-1:0] lrc_final(
    input logic                 mode,
    input logic [LRC_MAX_W-1:0] acc
  );
    logic [LRC_MAX_W-1:0] r;
    case (mode)
      LRC_XOR: r = acc;
      LRC_ADD: r = ~acc + LRC_MAX_W'(1);
      default: r = acc;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lrc_lane.sv
// lrc_lane: state for one channel of the LRC engine.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   acc_en       : a beat for this channel is being accepted this cycle
//   last         : that beat ends the frame
//   data         : beat payload
//   cfg_mode     : XOR(0) / additive(1), used only on the first beat
//   cfg_check    : last beat is a received LRC, used only on the first beat
//   res          : finalised LRC if the current beat were the last one
//   res_len      : data-beat count matching res
//   res_err      : check mismatch matching res
// The res* outputs are combinational views of "what the frame would produce
// if this beat closed it"; the top registers them only on an accepted last beat.
module lrc_lane
  import lrc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_en,
  input  logic              last,
  input  logic [DATA_W-1:0] data,
  input  logic              cfg_mode,
  input  logic              cfg_check,
  output logic [DATA_W-1:0] res,
  output logic [LEN_W-1:0]  res_len,
  output logic              res_err
);

  lane_state_t       state, state_nxt;
  logic [DATA_W-1:0] acc;
  logic [LEN_W-1:0]  len;
  logic              mode;
  logic              check;

  logic              eff_mode;
  logic              eff_check;
  logic [DATA_W-1:0] acc_fold;
  logic [LEN_W-1:0]  len_inc;
  logic [DATA_W-1:0] fin_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LANE_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (acc_en) begin
      state_nxt = last ? LANE_IDLE : LANE_ACTIVE;
    end
  end

  // While IDLE the beat on the bus is the frame's first beat, so its cfg
  // fields apply immediately; afterwards the latched copies are used.
  always_comb begin
    eff_mode  = (state == LANE_IDLE) ? cfg_mode  : mode;
    eff_check = (state == LANE_IDLE) ? cfg_check : check;
    acc_fold  = DATA_W'(lrc_fold(eff_mode, LRC_MAX_W'(acc), LRC_MAX_W'(data)));
    len_inc   = (len == {LEN_W{1'b1}}) ? len : len + LEN_W'(1);
    fin_val   = '0;
    res       = '0;
    res_len   = '0;
    res_err   = 1'b0;
    if (eff_check && last) begin
      // Check beat is not folded and not counted.
      fin_val = DATA_W'(lrc_final(eff_mode, LRC_MAX_W'(acc)));
      res     = fin_val;
      res_len = len;
      res_err = (fin_val != data);
    end else begin
      fin_val = DATA_W'(lrc_final(eff_mode, LRC_MAX_W'(acc_fold)));
      res     = fin_val;
      res_len = len_inc;
      res_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      len   <= '0;
      mode  <= LRC_XOR;
      check <= 1'b0;
    end else if (acc_en) begin
      if (last) begin
        acc   <= '0;
        len   <= '0;
        mode  <= LRC_XOR;
        check <= 1'b0;
      end else begin
        acc   <= acc_fold;
        len   <= len_inc;
        mode  <= eff_mode;
        check <= eff_check;
      end
    end
  end

endmodule

// File: rtl/lrc_stream.sv
// lrc_stream: multi-channel longitudinal redundancy check engine.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input beat handshake
//   in_data, in_ch        : beat payload and channel id
//   in_last               : final beat of the frame
//   cfg_mode, cfg_check   : frame configuration, sampled on the first beat
//   out_valid/out_ready   : result handshake
//   out_data, out_ch      : computed LRC and its channel
//   out_len               : data beats in the frame (check beat excluded)
//   out_err               : received LRC mismatch (check mode only)
//   bad_ch                : one-cycle pulse after a beat with in_ch >= NUM_CH
// One lrc_lane per channel holds the running state; this level does the
// handshake, channel decode and the single output register.
module lrc_stream
  import lrc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_ch,
  input  logic              in_last,
  input  logic              cfg_mode,
  input  logic              cfg_check,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_err,
  output logic              bad_ch
);

  logic              accept;
  logic              ch_ok;
  logic [NUM_CH-1:0] lane_en;
  logic [DATA_W-1:0] lane_res [NUM_CH];
  logic [LEN_W-1:0]  lane_len [NUM_CH];
  logic [NUM_CH-1:0] lane_err;

  logic [DATA_W-1:0] sel_res;
  logic [LEN_W-1:0]  sel_len;
  logic              sel_err;

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [CH_W-1:0]   ch_p1;
  logic [LEN_W-1:0]  len_p1;
  logic              err_p1;
  logic              bad_p1;

  // Stall only while a result is held and not being taken this cycle.
  assign in_ready = !rst && !(vld_p1 && !out_ready);
  assign accept   = in_valid && in_ready;
  // One extra bit so NUM_CH == 2**CH_W compares correctly.
  assign ch_ok    = ({1'b0, in_ch} < (CH_W + 1)'(NUM_CH));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign lane_en[i] = accept && ch_ok && (in_ch == CH_W'(i));

    lrc_lane #(
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .acc_en    (lane_en[i]),
      .last      (in_last),
      .data      (in_data),
      .cfg_mode  (cfg_mode),
      .cfg_check (cfg_check),
      .res       (lane_res[i]),
      .res_len   (lane_len[i]),
      .res_err   (lane_err[i])
    );
  end

  always_comb begin
    sel_res = '0;
    sel_len = '0;
    sel_err = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_ch == CH_W'(i)) begin
        sel_res = lane_res[i];
        sel_len = lane_len[i];
        sel_err = lane_err[i];
      end
    end
  end

  // Stage p1: result / bad-channel output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      len_p1  <= '0;
      err_p1  <= 1'b0;
      bad_p1  <= 1'b0;
    end else begin
      bad_p1 <= accept && !ch_ok;
      if (accept && ch_ok && in_last) begin
        // in_ready guarantees the old result is absent or leaving now.
        vld_p1  <= 1'b1;
        data_p1 <= sel_res;
        ch_p1   <= in_ch;
        len_p1  <= sel_len;
        err_p1  <= sel_err;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_ch    = ch_p1;
  assign out_len   = len_p1;
  assign out_err   = err_p1;
  assign bad_ch    = bad_p1;

endmodule

// File: doc/lrc_stream.md
Name: lrc_stream

Overview:
Multi-channel, parametrised longitudinal redundancy check engine. It is the successor to the fixed 8-bit single-stream LRC used in the Tiny Tapeout top.
- Accepts framed beats over a valid/ready stream, with beats from up to NUM_CH channels interleaved.
- Keeps one accumulator per channel.
- Supports XOR LRC and additive two's-complement LRC (Modbus-ASCII style).
- Emits one result per frame. In check mode it instead verifies a trailing received LRC beat.

Parameters:
- DATA_W, 8: beat and LRC width in bits.
- NUM_CH, 2: number of independent channels; NUM_CH must not exceed 2**CH_W.
- CH_W, 1: width of the channel-id fields.
- LEN_W, 16: width of the per-frame beat counter.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: engine can accept a beat.
- in_data, input, DATA_W: beat payload.
- in_ch, input, CH_W: channel id of the beat.
- in_last, input, 1: final beat of the frame.
- cfg_mode, input, 1: 0 = XOR, 1 = additive; sampled on the first beat of a frame.
- cfg_check, input, 1: 1 = last beat is a received LRC to verify; sampled on the first beat.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- out_data, output, DATA_W: computed LRC.
- out_ch, output, CH_W: channel of the result.
- out_len, output, LEN_W: data beats in the frame, excluding the check beat.
- out_err, output, 1: check mismatch; always 0 when check mode is off.
- bad_ch, output, 1: one-cycle pulse when a beat with in_ch >= NUM_CH is accepted.

Behaviour:
- Handshakes:
  - A beat transfers when in_valid && in_ready. A result transfers when out_valid && out_ready.
  - in_ready = !rst && !(out_valid && !out_ready), so the engine stalls only while a result is pending and not being taken.
- Reset (rst high at a clock edge):
  - out_valid, out_data, out_ch, out_len, out_err and bad_ch go to 0; in_ready is held at 0 while rst is high.
  - Every channel returns to IDLE with acc = 0 and len = 0. A frame in progress is discarded and produces no result.
- Per-channel state machine:
  - State: IDLE/ACTIVE, plus acc[DATA_W], mode, check and len[LEN_W].
  - First accepted beat while IDLE: latch cfg_mode and cfg_check, go to ACTIVE. If in_last is also set, it is a single-beat frame.
  - Accepted beat with !in_last:
    - XOR mode: acc ^= data.
    - Additive mode: acc += data, modulo 2**DATA_W.
    - len += 1, saturating at 2**LEN_W - 1.
  - Accepted beat with in_last:
    - check = 0: fold data in as above, then finalise.
    - check = 1: do not fold data; compare it against the finalised value.
    - Then: load the output register, clear the channel state, return to IDLE.
- Finalise:
  - XOR mode: result = acc.
  - Additive mode: result = (~acc + 1) truncated to DATA_W.
- Output register:
  - out_valid rises on the cycle after the last beat is accepted, so latency is 1 clock.
  - out_data = result; out_ch = channel; out_len = len, including the last beat only when check = 0.
  - out_err = check && (result != last data).
  - Outputs hold stable while out_valid && !out_ready.
- Simultaneous events:
  - If a last beat is accepted in the same cycle the pending result is taken, the new result loads with no bubble.
  - A beat for one channel never alters another channel's state.
- Single-beat frame with check = 1: result is 0 in both modes, len = 0, and err = (data != 0).
- Invalid channel id (in_ch >= NUM_CH): the beat is accepted and discarded, and bad_ch pulses on the next cycle. No channel state changes.
- Configuration changes: cfg_mode and cfg_check on beats after the first beat of a frame are ignored.

Decomposition:
- Package lrc_pkg:
  - localparams LRC_XOR = 1'b0 and LRC_ADD = 1'b1.
  - Function lrc_fold(mode, acc, data).
  - Function lrc_final(mode, acc).
- Sub-module lrc_lane: one channel's accumulator, length counter and mode/check latch. It has an accept/last strobe in and a final value, len and err out. lrc_stream instantiates it NUM_CH times via generate and adds the handshake and output register.

Test Plan:
- XOR generate: ch0, mode 0, check 0, beats 0x01, 0x02, 0x04 (last) -> one cycle later out_valid = 1, out_data = 0x07, out_len = 3, out_err = 0, out_ch = 0.
- Additive generate: ch1, mode 1, beats 0x01, 0x03, 0x00, 0x00, 0x00, 0x0A (last) -> out_data = 0xF2, out_len = 6, out_ch = 1.
- Additive check:
  - Same six beats plus 0xF2 as last with check = 1 -> out_data = 0xF2, out_len = 6, out_err = 0.
  - Repeat with last beat 0xF3 -> out_err = 1.
- Interleaving: ch0 beats 0x11, 0x22 alternating with ch1 beats 0x0F, 0xF0 (XOR; ch0 last on 0x22, ch1 last on 0xF0) -> ch0 result 0x33, then ch1 result 0xFF; no cross-contamination.
- Backpressure:
  - Hold out_ready = 0 after a result -> in_ready = 0 and out_data stable.
  - Raise out_ready in the same cycle a new last beat is presented -> next result appears on the following cycle with no gap.
- Reset and bad channel:
  - Assert rst after two beats of a frame -> all outputs 0; the next frame on that channel, beat 0x5A (last, XOR), gives out_data = 0x5A.
  - Send in_ch = 2 with NUM_CH = 2, CH_W = 2 -> bad_ch pulses once and no result is produced.
